// File: rtl/wts_key_event_scheduler.sv
// Per-channel key-event scheduler: holds CPU key commands until the next active strobe,
// turning key_on on a sounding channel into key_off followed by key_on on consecutive strobes.
module wts_key_event_scheduler #(
  parameter int CH     = 5,
  parameter bit RETRIG = 1'b1
) (
  input  logic            clk,
  input  logic            nreset,
  input  logic            active,
  input  logic            wr,
  input  logic [2:0]      wr_ch,
  input  logic [1:0]      wr_cmd,
  input  logic [CH*8-1:0] env_level,
  output logic [CH-1:0]   key_on,
  output logic [CH-1:0]   key_release,
  output logic [CH-1:0]   key_off,
  output logic [CH-1:0]   busy
);

  typedef enum logic [2:0] {
    IDLE, HOLD_ON, HOLD_REL, HOLD_OFF, RETRIG_OFF, RETRIG_ON
  } state_t;

  localparam logic [3:0] CH_W = 4'(CH);

  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [CH-1:0] key_on_d, key_release_d, key_off_d, busy_d;
  logic          wr_ok;

  assign wr_ok = wr && (wr_cmd != 2'd0) && ({1'b0, wr_ch} < CH_W);

  always_comb begin
    key_on_d      = '0;
    key_release_d = '0;
    key_off_d     = '0;
    busy_d        = '0;
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      if (active) begin
        case (state_q[i])
          HOLD_ON, HOLD_REL, HOLD_OFF: state_d[i] = IDLE;
          RETRIG_OFF:                  state_d[i] = RETRIG_ON;
          RETRIG_ON:                   state_d[i] = IDLE;
          default:                     state_d[i] = state_q[i];
        endcase
      end
      // A write in the consuming cycle overrides; the consumed level is still on the output this cycle.
      if (wr_ok && (wr_ch == 3'(i))) begin
        case (wr_cmd)
          2'd1:    state_d[i] = (RETRIG && (env_level[8*i +: 8] != 8'd0)) ? RETRIG_OFF : HOLD_ON;
          2'd2:    state_d[i] = HOLD_REL;
          default: state_d[i] = HOLD_OFF;
        endcase
      end
      key_on_d[i]      = (state_d[i] == HOLD_ON) || (state_d[i] == RETRIG_ON);
      key_release_d[i] = (state_d[i] == HOLD_REL);
      key_off_d[i]     = (state_d[i] == HOLD_OFF) || (state_d[i] == RETRIG_OFF);
      busy_d[i]        = (state_d[i] != IDLE);
    end
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < CH; i++) state_q[i] <= IDLE;
      key_on      <= '0;
      key_release <= '0;
      key_off     <= '0;
      busy        <= '0;
    end else begin
      for (int i = 0; i < CH; i++) state_q[i] <= state_d[i];
      key_on      <= key_on_d;
      key_release <= key_release_d;
      key_off     <= key_off_d;
      busy        <= busy_d;
    end
  end

endmodule

// File: tb/tb_wts_key_event_scheduler.sv
// Bench for wts_key_event_scheduler: per-channel delivery-queue model plus directed literal checks.
module tb_wts_key_event_scheduler;
  localparam int CH = 5;

  logic          clk = 1'b0;
  logic          nreset;
  logic          active, wr;
  logic [2:0]    wr_ch;
  logic [1:0]    wr_cmd;
  logic [CH*8-1:0] env_level;
  logic [CH-1:0] key_on, key_release, key_off, busy;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: each channel holds a list (max 2) of levels still to be delivered; head is driven.
  int mlen [CH];
  int mhead[CH];
  int msec [CH];

  wts_key_event_scheduler #(.CH(CH), .RETRIG(1'b1)) dut (
    .clk(clk), .nreset(nreset), .active(active), .wr(wr), .wr_ch(wr_ch),
    .wr_cmd(wr_cmd), .env_level(env_level), .key_on(key_on),
    .key_release(key_release), .key_off(key_off), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [CH-1:0] act, input logic [CH-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < CH; c++) begin
      mlen[c] = 0; mhead[c] = 0; msec[c] = 0;
    end
  endtask

  task automatic model_step();
    for (int c = 0; c < CH; c++) begin
      if (active && mlen[c] > 0) begin
        mhead[c] = msec[c];
        mlen[c]  = mlen[c] - 1;
      end
      if (wr && wr_cmd != 2'd0 && int'(wr_ch) == c) begin
        if (wr_cmd == 2'd1 && env_level[8*c +: 8] != 8'd0) begin
          mhead[c] = 3; msec[c] = 1; mlen[c] = 2;
        end else begin
          mhead[c] = int'(wr_cmd); mlen[c] = 1;
        end
      end
    end
  endtask

  task automatic model_compare();
    logic [CH-1:0] e_on, e_rel, e_off, e_busy;
    for (int c = 0; c < CH; c++) begin
      e_busy[c] = (mlen[c] > 0);
      e_on[c]   = (mlen[c] > 0) && (mhead[c] == 1);
      e_rel[c]  = (mlen[c] > 0) && (mhead[c] == 2);
      e_off[c]  = (mlen[c] > 0) && (mhead[c] == 3);
    end
    chk("model key_on", key_on, e_on);
    chk("model key_release", key_release, e_rel);
    chk("model key_off", key_off, e_off);
    chk("model busy", busy, e_busy);
  endtask

  // Drive one cycle's inputs at negedge, advance the model at posedge, compare at next negedge.
  task automatic cyc(input logic w, input int ch, input int cmd, input logic act);
    wr = w; wr_ch = 3'(ch); wr_cmd = 2'(cmd); active = act;
    @(posedge clk);
    model_step();
    @(negedge clk);
    model_compare();
  endtask

  initial begin
    nreset = 1'b0; active = 1'b0; wr = 1'b0; wr_ch = '0; wr_cmd = '0; env_level = '0;
    model_clear();
    repeat (2) @(negedge clk);
    chk("reset key_on", key_on, 5'b0);
    chk("reset key_release", key_release, 5'b0);
    chk("reset key_off", key_off, 5'b0);
    chk("reset busy", busy, 5'b0);
    nreset = 1'b1;
    @(negedge clk);

    // key_on to silent ch2, strobe 6 clocks after the write
    cyc(1'b1, 2, 1, 1'b0);
    for (int k = 0; k < 5; k++) begin
      chk("ch2 key_on held", key_on, 5'b00100);
      cyc(1'b0, 0, 0, 1'b0);
    end
    chk("ch2 key_on held", key_on, 5'b00100);
    chk("ch2 no key_off", key_off, 5'b0);
    cyc(1'b0, 0, 0, 1'b1);
    chk("ch2 key_on consumed", key_on, 5'b0);

    // retrigger on sounding ch1
    env_level[15:8] = 8'd64;
    cyc(1'b1, 1, 1, 1'b0);
    chk("ch1 retrig key_off", key_off, 5'b00010);
    chk("ch1 retrig key_on low", key_on, 5'b0);
    cyc(1'b0, 0, 0, 1'b1);
    chk("ch1 after strobe1 key_on", key_on, 5'b00010);
    chk("ch1 after strobe1 key_off", key_off, 5'b0);
    chk("ch1 after strobe1 busy", busy, 5'b00010);
    cyc(1'b0, 0, 0, 1'b1);
    chk("ch1 after strobe2 busy", busy, 5'b0);
    chk("ch1 after strobe2 key_on", key_on, 5'b0);
    env_level = '0;

    // key_release written in an active cycle survives that strobe
    cyc(1'b1, 0, 2, 1'b1);
    chk("ch0 release survives", key_release, 5'b00001);
    cyc(1'b0, 0, 0, 1'b1);
    chk("ch0 release consumed", key_release, 5'b0);

    // key_on overwritten by key_off before any strobe
    cyc(1'b1, 3, 1, 1'b0);
    cyc(1'b1, 3, 3, 1'b0);
    chk("ch3 key_off wins", key_off, 5'b01000);
    chk("ch3 key_on dropped", key_on, 5'b0);
    cyc(1'b0, 0, 0, 1'b1);
    chk("ch3 all consumed", busy, 5'b0);

    // ignored writes
    cyc(1'b1, 7, 1, 1'b0);
    cyc(1'b1, 2, 0, 1'b0);
    chk("ignored writes busy", busy, 5'b0);

    // async reset drops a pending HOLD_ON immediately
    cyc(1'b1, 4, 1, 1'b0);
    chk("ch4 pending key_on", key_on, 5'b10000);
    wr = 1'b0;
    #2 nreset = 1'b0;
    #1;
    chk("async reset key_on", key_on, 5'b0);
    chk("async reset busy", busy, 5'b0);
    model_clear();
    @(negedge clk);
    nreset = 1'b1;

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      for (int c = 0; c < CH; c++)
        env_level[8*c +: 8] = ($urandom_range(1) == 0) ? 8'd0 : 8'($urandom_range(255, 1));
      cyc(($urandom_range(1) == 1), int'($urandom_range(7)), int'($urandom_range(3)),
          ($urandom_range(3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
